// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - CPU, debug and memory bus bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic          cpu_rd;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_halt;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt;
  logic          dbg_done;
  logic [DW-1:0] dbg_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, cpu_halt,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_done, dbg_rdata,
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, cpu_halt,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_done, dbg_rdata,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/debug arbiter for the shared program/data memory
module mem_arbiter #(
  parameter int AW       = 5,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 4,
  parameter int CW       = 16
) (
  input  logic          clock,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output logic [CW-1:0] stall_cnt
);
  localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  typedef enum logic {CPU_OWN, DBG_OWN} state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wait_cnt;
  logic          done_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;

  logic          cpu_act, pending, take;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_read, mem_write, cpu_stall, dbg_gnt;

  assign cpu_act = (bus.cpu_rd | bus.cpu_wr) & ~bus.cpu_halt;
  // The done cycle masks dbg_req so the CPU always gets a slot between debug accesses.
  assign pending = bus.dbg_req & ~done_q;

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    mem_addr  = bus.cpu_addr;
    mem_wdata = bus.cpu_wdata;
    mem_read  = bus.cpu_rd & ~bus.cpu_halt;
    mem_write = bus.cpu_wr & ~bus.cpu_halt;
    cpu_stall = 1'b0;
    dbg_gnt   = 1'b0;
    case (state)
      CPU_OWN: begin
        if (pending && (!cpu_act || wait_cnt == WMAX)) begin
          take      = 1'b1;
          state_nxt = DBG_OWN;
        end
      end
      DBG_OWN: begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_write = we_q;
        mem_read  = ~we_q;
        cpu_stall = cpu_act;
        dbg_gnt   = 1'b1;
        state_nxt = CPU_OWN;
      end
      default: state_nxt = CPU_OWN;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state     <= CPU_OWN;
      wait_cnt  <= '0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      stall_cnt <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == DBG_OWN);
      if (take) begin
        we_q     <= bus.dbg_we;
        addr_q   <= bus.dbg_addr;
        wdata_q  <= bus.dbg_wdata;
        wait_cnt <= '0;
      end else if (state == CPU_OWN && pending) begin
        if (wait_cnt != WMAX) wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (state == DBG_OWN && !we_q) rdata_q <= bus.mem_rdata;
      if (cpu_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.cpu_stall = cpu_stall;
  assign bus.dbg_gnt   = dbg_gnt;
  assign bus.dbg_done  = done_q;
  assign bus.dbg_rdata = rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a cycle-level reference model
module tb_mem_arbiter;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int MAX_WAIT = 4;
  localparam int CW = 16;
  localparam int PMAX = 1600;

  logic clock = 1'b0;
  logic rst = 1'b1;
  logic [CW-1:0] stall_cnt;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .CW(CW)) dut (
    .clock(clock), .rst(rst), .bus(bus), .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] mem_arr [32];
  logic [DW-1:0] init_arr [32];
  logic [DW-1:0] ref_mem [32];
  logic init_mem = 1'b1;

  assign bus.mem_rdata = mem_arr[bus.mem_addr];
  always @(posedge clock) begin
    if (init_mem) mem_arr <= init_arr;
    else if (bus.mem_write) mem_arr[bus.mem_addr] <= bus.mem_wdata;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int            gnt;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;
  txn_t sb[$];

  bit            rd_p [PMAX+8];
  bit            hl_p [PMAX+8];
  logic [AW-1:0] ad_p [PMAX+8];
  int  t_now = 0;
  bit  rand_on = 1'b0;
  int  exp_stalls = 0;
  bit  pend = 1'b0;
  int  p_gnt;
  bit  p_we;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;

  function automatic bit act_at(input int c);
    return rd_p[c] && !hl_p[c];
  endfunction

  // A pending request wins the first CPU-idle cycle, or is forced once it has lost MAX_WAIT cycles.
  function automatic int calc_gnt(input int start);
    int c = start;
    while (act_at(c) && (c - start) < MAX_WAIT) c++;
    return c + 1;
  endfunction

  task automatic new_req(input int start, input int mode);
    txn_t x;
    p_we    = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    p_addr  = (mode == 0) ? AW'($urandom_range(0, 31)) : ((mode == 1) ? 5'h1D : 5'h00);
    p_wdata = DW'($urandom);
    p_gnt   = calc_gnt(start);
    if (act_at(p_gnt)) exp_stalls++;
    x.gnt = p_gnt; x.we = p_we; x.addr = p_addr; x.wdata = p_wdata; x.rdata = ref_mem[p_addr];
    sb.push_back(x);
    bus.dbg_req = 1'b1; bus.dbg_we = p_we; bus.dbg_addr = p_addr; bus.dbg_wdata = p_wdata;
    pend = 1'b1;
  endtask

  bit eg, ed;
  always @(negedge clock) begin
    if (rand_on) begin
      eg = 1'b0; ed = 1'b0;
      if (sb.size() > 0) begin
        eg = (sb[0].gnt == t_now);
        ed = (sb[0].gnt + 1 == t_now);
      end
      chk("dbg_gnt", bus.dbg_gnt, eg);
      chk("dbg_done", bus.dbg_done, ed);
      if (eg) begin
        chk("gnt_addr", bus.mem_addr, sb[0].addr);
        chk("gnt_write", bus.mem_write, sb[0].we);
        chk("gnt_read", bus.mem_read, !sb[0].we);
        if (sb[0].we) chk("gnt_wdata", bus.mem_wdata, sb[0].wdata);
        chk("gnt_stall", bus.cpu_stall, act_at(t_now));
      end else begin
        chk("cpu_stall", bus.cpu_stall, 1'b0);
        chk("cpu_read", bus.mem_read, act_at(t_now));
        if (act_at(t_now)) begin
          chk("cpu_addr", bus.mem_addr, ad_p[t_now]);
          chk("cpu_rdata", bus.cpu_rdata, ref_mem[ad_p[t_now]]);
        end
      end
      if (ed) begin
        if (!sb[0].we) chk("dbg_rdata", bus.dbg_rdata, sb[0].rdata);
        void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_halt = 1'b0;
    bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
  endtask

  // mode 0: random traffic; mode 1: CPU reads every cycle; mode 2: CPU halted with cpu_rd held
  task automatic run_phase(input int mode, input int len);
    for (int i = 0; i < len + 8; i++) begin
      rd_p[i] = (mode == 0) ? ($urandom_range(0, 9) < 7) : 1'b1;
      hl_p[i] = (mode == 0) ? ($urandom_range(0, 19) == 0) : (mode == 2);
      ad_p[i] = AW'($urandom_range(0, 31));
    end
    pend = 1'b0;
    for (int t = 0; t < len; t++) begin
      tick();
      t_now = t;
      bus.cpu_rd = rd_p[t]; bus.cpu_halt = hl_p[t]; bus.cpu_addr = ad_p[t];
      bus.cpu_wdata = DW'($urandom); bus.cpu_wr = 1'b0;
      if (pend && t == p_gnt + 1) begin
        if (p_we) ref_mem[p_addr] = p_wdata;
        pend = 1'b0;
        if (t < len - 20 && $urandom_range(0, 1) == 1) new_req(t + 1, mode);
        else bus.dbg_req = 1'b0;
      end else if (!pend && t < len - 20 && $urandom_range(0, 3) == 0) begin
        new_req(t, mode);
      end
      rand_on = 1'b1;
    end
    @(negedge clock);
    rand_on = 1'b0;
    tick();
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] old5;
    int bad;
    for (int i = 0; i < 32; i++) begin
      init_arr[i] = DW'($urandom);
    end
    init_arr[5'h1B] = 8'h90;
    init_arr[5'h1D] = 8'h07;
    ref_mem = init_arr;
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    @(negedge clock);
    chk("rst_gnt", bus.dbg_gnt, 1'b0);
    chk("rst_done", bus.dbg_done, 1'b0);
    chk("rst_stall", bus.cpu_stall, 1'b0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_dbg_rdata", bus.dbg_rdata, 0);
    tick();
    rst = 1'b0; init_mem = 1'b0;

    bus.cpu_rd = 1'b1; bus.cpu_addr = 5'h1B;
    @(negedge clock);
    chk("cpu_only_read", bus.mem_read, 1'b1);
    chk("cpu_only_addr", bus.mem_addr, 5'h1B);
    chk("cpu_only_rdata", bus.cpu_rdata, 8'h90);
    chk("cpu_only_stall", bus.cpu_stall, 1'b0);
    chk("cpu_only_stall_cnt", stall_cnt, 0);
    tick();
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b1; bus.cpu_addr = 5'h03; bus.cpu_wdata = 8'h3C;
    @(negedge clock);
    chk("cpu_wr_pass", bus.mem_write, 1'b1);
    chk("cpu_wr_data", bus.mem_wdata, 8'h3C);
    tick();
    ref_mem[3] = 8'h3C;
    idle_inputs();

    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 5'h1A; bus.dbg_wdata = 8'h55;
    @(negedge clock);
    chk("dw_gnt_n", bus.dbg_gnt, 1'b0);
    tick();
    @(negedge clock);
    chk("dw_gnt", bus.dbg_gnt, 1'b1);
    chk("dw_write", bus.mem_write, 1'b1);
    chk("dw_addr", bus.mem_addr, 5'h1A);
    chk("dw_wdata", bus.mem_wdata, 8'h55);
    tick();
    bus.dbg_req = 1'b0;
    @(negedge clock);
    chk("dw_done", bus.dbg_done, 1'b1);
    chk("dw_mem", mem_arr[5'h1A], 8'h55);
    chk("dw_rdata_kept", bus.dbg_rdata, 0);
    ref_mem[5'h1A] = 8'h55;
    tick();
    @(negedge clock);
    chk("dw_done_pulse", bus.dbg_done, 1'b0);

    run_phase(1, 80);
    run_phase(2, 80);
    run_phase(0, 1500);
    @(negedge clock);
    chk("stall_cnt", stall_cnt, exp_stalls);
    chk("sb_drained", sb.size(), 0);
    bad = 0;
    for (int i = 0; i < 32; i++) if (mem_arr[i] !== ref_mem[i]) bad++;
    chk("mem_image", bad, 0);

    tick();
    old5 = ref_mem[5];
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 5'h05; bus.dbg_wdata = ~old5;
    tick();
    bus.cpu_rd = 1'b1; bus.cpu_addr = 5'h00;
    #1;
    chk("rst_mid_gnt_pre", bus.dbg_gnt, 1'b1);
    chk("rst_mid_stall_pre", bus.cpu_stall, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid_write", bus.mem_write, 1'b0);
    chk("rst_mid_gnt", bus.dbg_gnt, 1'b0);
    chk("rst_mid_stall", bus.cpu_stall, 1'b0);
    idle_inputs();
    tick();
    rst = 1'b0;
    @(negedge clock);
    chk("rst_mid_done0", bus.dbg_done, 1'b0);
    tick();
    @(negedge clock);
    chk("rst_mid_done1", bus.dbg_done, 1'b0);
    chk("rst_mid_stall_cnt", stall_cnt, 0);
    chk("rst_mid_mem", mem_arr[5], old5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
